// File: rtl/melody_seq.sv
// Note sequencer: steps through a writable (K, duration) table and drives the
// K / en inputs of the downstream programmable clock divider.
module melody_seq #(
    parameter int N_BIT     = 16,
    parameter int ADDR_W    = 4,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N_BIT-1:0]  wr_k,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [N_BIT-1:0]  K,
    output logic              en,
    output logic              busy,
    output logic [ADDR_W-1:0] idx,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0]     GAP_LAST   = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W:0]   DEPTH_V    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);
    localparam logic [DUR_W-1:0]  DUR_ONE    = DUR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
    localparam logic [N_BIT-1:0]  K_MIN      = N_BIT'(2);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

    state_t            state;
    logic [N_BIT-1:0]  k_mem   [DEPTH];
    logic [DUR_W-1:0]  dur_mem [DEPTH];
    logic [PW-1:0]     presc;
    logic [DUR_W-1:0]  dur_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [ADDR_W:0]   len_q;

    logic [N_BIT-1:0]  fk;
    logic [DUR_W-1:0]  fd;
    logic              tick;
    logic              last;
    logic              adv;

    // Table is deliberately not reset; a same-edge fetch sees the pre-write contents.
    always_ff @(posedge clkin) begin
        if (wr_en) begin
            k_mem[wr_addr]   <= wr_k;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    always_comb begin
        fk   = k_mem[idx];
        fd   = dur_mem[idx];
        tick = (presc == PRESC_LAST);
        last = ({1'b0, idx} == (len_q - LEN_ONE));
        adv  = ((state == S_PLAY) && tick && (dur_cnt == DUR_ONE) && (GAP_TICKS == 0)) ||
               ((state == S_GAP)  && tick && (gap_cnt == GAP_LAST));
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            K       <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
            presc   <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            len_q   <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state != S_IDLE) begin
                state <= S_IDLE;
                K     <= '0;
                en    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        K  <= '0;
                        en <= 1'b0;
                        if (start && !stop && len != '0) begin
                            len_q <= (len > DEPTH_V) ? DEPTH_V : len;
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        K       <= {fk[N_BIT-1:1], 1'b0};
                        en      <= (fk >= K_MIN);
                        dur_cnt <= (fd == '0) ? DUR_ONE : fd;
                        presc   <= '0;
                        state   <= S_PLAY;
                    end
                    S_PLAY: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            dur_cnt <= dur_cnt - DUR_ONE;
                            if (dur_cnt == DUR_ONE) begin
                                en <= 1'b0;
                                if (GAP_TICKS > 0) begin
                                    gap_cnt <= '0;
                                    state   <= S_GAP;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick && gap_cnt != GAP_LAST)
                            gap_cnt <= gap_cnt + GW'(1);
                    end
                    default: state <= S_IDLE;
                endcase

                // End of note (after the gap, if any): next entry, wrap, or finish.
                if (adv) begin
                    if (last) begin
                        if (loop) begin
                            idx   <= '0;
                            state <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            K     <= '0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= S_FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq: TICK_DIV=4 with GAP_TICKS=1 (dut) and GAP_TICKS=0 (dut0).
module tb_melody_seq;

    logic        clkin = 1'b0;
    logic        rst, wr_en, start, stop, loop;
    logic [3:0]  wr_addr;
    logic [15:0] wr_k;
    logic [7:0]  wr_dur;
    logic [4:0]  len;

    logic [15:0] K, K0;
    logic        en, busy, done, en0, busy0, done0;
    logic [3:0]  idx, idx0;

    int n_cmp = 0;
    int n_bad = 0;
    int dcnt;

    melody_seq #(.N_BIT(16), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(1)) dut (
        .clkin(clkin), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_k(wr_k),
        .wr_dur(wr_dur), .len(len), .start(start), .stop(stop), .loop(loop),
        .K(K), .en(en), .busy(busy), .idx(idx), .done(done));

    melody_seq #(.N_BIT(16), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(0)) dut0 (
        .clkin(clkin), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_k(wr_k),
        .wr_dur(wr_dur), .len(len), .start(start), .stop(stop), .loop(loop),
        .K(K0), .en(en0), .busy(busy0), .idx(idx0), .done(done0));

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] k, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_k = k; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; start = 0; stop = 0; loop = 0;
        wr_addr = 0; wr_k = 0; wr_dur = 0; len = 0;
        tick(); tick();
        chk("rst_K", K, 0); chk("rst_en", en, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_idx", idx, 0);
        rst = 1'b0;
        tick();

        // Three-entry table, single pass
        wr(0, 100, 2); wr(1, 0, 1); wr(2, 51, 1);
        len = 3; loop = 0; start = 1;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 1) start = 0;
            case (e)
                1:  begin chk("t1_busy_fetch", busy, 1); chk("t1_busy0_fetch", busy0, 1); end
                2:  begin chk("t1_K0", K, 100); chk("t1_en0", en, 1); chk("t1_idx0", idx, 0); end
                9:  chk("t1_en_hold", en, 1);
                10: begin chk("t1_en_off", en, 0); chk("t1_K_gap", K, 100);
                          chk("g0_idx1", idx0, 1); chk("g0_en_off", en0, 0); end
                14: chk("t1_idx1", idx, 1);
                15: begin chk("t1_rest_K", K, 0); chk("t1_rest_en", en, 0); end
                16: begin chk("g0_K2", K0, 50); chk("g0_en2", en0, 1); chk("g0_idx2", idx0, 2); end
                20: begin chk("g0_done", done0, 1); chk("g0_busy", busy0, 0); chk("g0_Kend", K0, 0); end
                23: chk("t1_idx2", idx, 2);
                24: begin chk("t1_K2", K, 50); chk("t1_en2", en, 1); end
                27: chk("t1_en2_hold", en, 1);
                28: chk("t1_en2_off", en, 0);
                31: begin chk("t1_done_early", done, 0); chk("t1_busy_gap", busy, 1); end
                32: begin chk("t1_done", done, 1); chk("t1_busy_end", busy, 0); chk("t1_K_end", K, 0); end
                33: chk("t1_done_pulse", done, 0);
                default: ;
            endcase
        end

        // Looping, with entry 0 rewritten while it plays
        loop = 1; start = 1; dcnt = 0;
        for (int e = 1; e <= 46; e++) begin
            tick();
            if (done) dcnt++;
            if (e == 1) start = 0;
            if (e == 4) begin wr_en = 1; wr_addr = 0; wr_k = 200; wr_dur = 2; end
            if (e == 5) wr_en = 0;
            if (e == 45) stop = 1;
            if (e == 46) stop = 0;
            case (e)
                2:  chk("lp_idx0", idx, 0);
                6:  chk("lp_K_keep", K, 100);
                14: chk("lp_idx1", idx, 1);
                23: chk("lp_idx2", idx, 2);
                32: begin chk("lp_wrap_idx", idx, 0); chk("lp_wrap_busy", busy, 1); end
                33: begin chk("lp_K_new", K, 200); chk("lp_en_new", en, 1); end
                45: chk("lp_idx1b", idx, 1);
                46: begin chk("stop_K", K, 0); chk("stop_en", en, 0); chk("stop_busy", busy, 0); end
                default: ;
            endcase
        end
        chk("lp_no_done", dcnt, 0);
        loop = 0;

        // len=0 start is ignored
        len = 0; start = 1;
        tick(); tick();
        start = 0;
        chk("len0_busy", busy, 0); chk("len0_K", K, 0);

        // dur=0 plays one tick; same-edge write/fetch takes old data
        wr(0, 100, 0);
        len = 1; start = 1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) begin start = 0; wr_en = 1; wr_addr = 0; wr_k = 300; wr_dur = 5; end
            if (e == 2) wr_en = 0;
            case (e)
                2:  begin chk("d0_K_old", K, 100); chk("d0_en", en, 1); end
                5:  chk("d0_en_hold", en, 1);
                6:  chk("d0_en_off", en, 0);
                10: chk("d0_done", done, 1);
                default: ;
            endcase
        end
        start = 1;
        tick(); start = 0; tick();
        chk("wf_K_new", K, 300);
        stop = 1; tick(); stop = 0;

        // len=20 clamps to the 16-entry table
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(10 + 2 * i), 0);
        len = 20; start = 1;
        for (int e = 1; e <= 146; e++) begin
            tick();
            if (e == 1) start = 0;
            case (e)
                2:   begin chk("cl_idx0", idx, 0); chk("cl_K0", K, 10); end
                11:  chk("cl_idx1", idx, 1);
                137: begin chk("cl_idx15", idx, 15); chk("cl_K15", K, 40); chk("cl_en15", en, 1); end
                144: begin chk("cl_done_early", done, 0); chk("cl_busy", busy, 1); end
                145: begin chk("cl_done", done, 1); chk("cl_busy_end", busy, 0); end
                146: chk("cl_idle", busy, 0);
                default: ;
            endcase
        end

        // Asynchronous reset mid-PLAY, then replay from entry 0
        len = 16; start = 1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 1) start = 0;
        end
        chk("ar_pre_idx", idx, 1); chk("ar_pre_en", en, 1);
        #2 rst = 1;
        #1;
        chk("ar_K", K, 0); chk("ar_en", en, 0); chk("ar_busy", busy, 0); chk("ar_idx", idx, 0);
        #2 rst = 0;
        start = 1;
        tick(); start = 0; tick();
        chk("ar_re_idx", idx, 0); chk("ar_re_K", K, 10); chk("ar_re_en", en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
